// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: exception codes, default handler pc and the
// per-edge control decode used by every stage boundary register.
package pipe_pkg;

  localparam logic [4:0] EXC_NONE    = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BP      = 5'd9;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef enum logic [2:0] {
    CTL_RST,
    CTL_INT,
    CTL_CLR,
    CTL_HOLD,
    CTL_LOAD
  } stage_ctl_e;

  // Fixed priority: reset > intReq > clr > stall > load.
  function automatic stage_ctl_e decode_ctl(input logic reset, input logic int_req,
                                            input logic clr, input logic stall);
    if (reset)        return CTL_RST;
    else if (int_req) return CTL_INT;
    else if (clr)     return CTL_CLR;
    else if (stall)   return CTL_HOLD;
    else              return CTL_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Control, upstream and registered signals of one pipeline stage boundary.
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 101,
  parameter int PC_W      = 32,
  parameter int EXC_W     = 5,
  parameter int CNT_W     = 16
) ();

  logic                 intReq;
  logic                 clr;
  logic                 stall;
  logic                 in_valid;
  logic [31:0]          in_instr;
  logic [PC_W-1:0]      in_pc;
  logic                 in_isBD;
  logic [EXC_W-1:0]     in_exCode;
  logic [EXC_W-1:0]     in_newExCode;
  logic [PAYLOAD_W-1:0] in_payload;

  logic                 out_valid;
  logic [31:0]          out_instr;
  logic [PC_W-1:0]      out_pc;
  logic                 out_isBD;
  logic [EXC_W-1:0]     out_exCode;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     bubble_cnt;

  modport master (
    output intReq, clr, stall, in_valid, in_instr, in_pc, in_isBD,
           in_exCode, in_newExCode, in_payload,
    input  out_valid, out_instr, out_pc, out_isBD, out_exCode, out_payload,
           stall_cnt, bubble_cnt
  );

  modport slave (
    input  intReq, clr, stall, in_valid, in_instr, in_pc, in_isBD,
           in_exCode, in_newExCode, in_payload,
    output out_valid, out_instr, out_pc, out_isBD, out_exCode, out_payload,
           stall_cnt, bubble_cnt
  );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}}))
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Stage-boundary register with stall/bubble/redirect control, exception-code
// merge on load and saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              PAYLOAD_W    = 101,
  parameter int              PC_W         = 32,
  parameter int              EXC_W        = 5,
  parameter logic [PC_W-1:0] HANDLER_PC   = PC_W'(HANDLER_PC_DEF),
  parameter int              CNT_W        = 16,
  parameter bit              CLR_KEEPS_PC = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  pipe_stage_reg_if.slave bus
);

  stage_ctl_e ctl;

  logic                 valid_q,   valid_d;
  logic [31:0]          instr_q,   instr_d;
  logic [PC_W-1:0]      pc_q,      pc_d;
  logic                 isbd_q,    isbd_d;
  logic [EXC_W-1:0]     exc_q,     exc_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  assign ctl = decode_ctl(reset, bus.intReq, bus.clr, bus.stall);

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    isbd_d    = isbd_q;
    exc_d     = exc_q;
    payload_d = payload_q;
    unique case (ctl)
      CTL_RST: begin
        valid_d   = 1'b0;
        instr_d   = '0;
        pc_d      = '0;
        isbd_d    = 1'b0;
        exc_d     = '0;
        payload_d = '0;
      end
      CTL_INT: begin
        valid_d   = 1'b0;
        instr_d   = '0;
        pc_d      = HANDLER_PC;
        isbd_d    = 1'b0;
        exc_d     = '0;
        payload_d = '0;
      end
      CTL_CLR: begin
        // A bubble may keep pc/BD so the slot still reports a meaningful EPC.
        valid_d   = 1'b0;
        instr_d   = '0;
        pc_d      = CLR_KEEPS_PC ? bus.in_pc : '0;
        isbd_d    = CLR_KEEPS_PC ? bus.in_isBD : 1'b0;
        exc_d     = '0;
        payload_d = '0;
      end
      CTL_HOLD: begin
      end
      CTL_LOAD: begin
        valid_d   = bus.in_valid;
        instr_d   = bus.in_instr;
        pc_d      = bus.in_pc;
        isbd_d    = bus.in_isBD;
        // The earliest stage's exception takes precedence.
        exc_d     = (bus.in_exCode != EXC_W'(EXC_NONE)) ? bus.in_exCode : bus.in_newExCode;
        payload_d = bus.in_payload;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      isbd_q    <= 1'b0;
      exc_q     <= '0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      isbd_q    <= isbd_d;
      exc_q     <= exc_d;
      payload_q <= payload_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctl == CTL_HOLD),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctl == CTL_CLR),
    .count (bus.bubble_cnt)
  );

  assign bus.out_valid   = valid_q;
  assign bus.out_instr   = instr_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_isBD    = isbd_q;
  assign bus.out_exCode  = exc_q;
  assign bus.out_payload = payload_q;

endmodule
